// File: rtl/casez_sel_enc.sv
// Priority-select encoder: maps 4-bit result codes to canonical casez sel vectors
// through a 2-entry output FIFO. Optional macro CASEZ_ENC_ERRCNT_EN adds err_cnt.
module casez_sel_enc #(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_code,
    output logic       in_ready,
    output logic       out_valid,
    output logic [3:0] out_sel,
    input  logic       out_ready,
    output logic       err
`ifdef CASEZ_ENC_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned MAX_CODE = 4;

    // out_sel doubles as the FIFO head entry, so it naturally holds the last popped value
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CODE_W-1:0] tail, tail_nxt, head_nxt;
    logic [CODE_W-1:0] enc_sel;
    logic              legal, acc, push, pop, bad;
    logic              out_valid_nxt, in_ready_nxt;

    always_comb begin
        enc_sel = 4'b0000;
        case (in_code)
            4'd1:    enc_sel = 4'b1000;
            4'd2:    enc_sel = 4'b0100;
            4'd3:    enc_sel = 4'b0010;
            4'd4:    enc_sel = 4'b0001;
            default: enc_sel = 4'b0000;
        endcase
    end

    assign legal = (in_code <= CODE_W'(MAX_CODE));
    assign acc   = in_valid && in_ready;
    assign push  = acc && legal;
    assign bad   = acc && !legal;
    assign pop   = out_valid && out_ready;

    // Occupancy update; a push is impossible when full because in_ready is low
    always_comb begin
        cnt_nxt  = cnt;
        head_nxt = out_sel;
        tail_nxt = tail;
        case (cnt)
            2'd0: begin
                if (push) begin
                    head_nxt = enc_sel;
                    cnt_nxt  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_nxt = enc_sel;
                end else if (push) begin
                    tail_nxt = enc_sel;
                    cnt_nxt  = 2'd2;
                end else if (pop) begin
                    cnt_nxt  = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_nxt = tail;
                    cnt_nxt  = 2'd1;
                end
            end
        endcase
        out_valid_nxt = (cnt_nxt != 2'd0);
        in_ready_nxt  = (cnt_nxt < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            tail      <= 4'b0000;
            out_sel   <= 4'b0000;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            err       <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            tail      <= tail_nxt;
            out_sel   <= head_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
            err       <= bad;
        end
    end

`ifdef CASEZ_ENC_ERRCNT_EN
    // Saturating count of rejected codes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (bad && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
